// File: rtl/obstacle_field.sv
// Scrolling ROWS x COLS pipe bitmap with an LFSR-driven column generator, pass scoring and read/collision ports.
// Read and collision ports answer one cycle after the query. Scrolling is gated by run; clear wins over step.
module obstacle_field #(
  parameter int          ROWS     = 30,
  parameter int          COLS     = 40,
  parameter int          PIPE_W   = 2,
  parameter int          SPACING  = 8,
  parameter int          GAP_H    = 10,
  parameter int          MARGIN   = 2,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          PASS_COL = 35,
  parameter int          SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               clear,
  input  logic [5:0]         rd_col,
  input  logic [5:0]         rd_row,
  output logic               rd_data,
  input  logic [5:0]         q_col,
  input  logic [5:0]         q_lo,
  input  logic [5:0]         q_hi,
  output logic               hit,
  output logic               pipe_pass,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         gen_state
);

  typedef enum logic [1:0] {
    SPACE = 2'd0,
    PIPE  = 2'd1
  } gen_t;

  localparam int RANGE = ROWS - 2*MARGIN - GAP_H + 1;

  logic [ROWS-1:0] field [COLS];
  logic [COLS-1:0] marker;
  gen_t            state;
  logic [15:0]     cnt;
  logic [15:0]     pcnt;
  logic [15:0]     lfsr;
  logic [6:0]      gap_top;

  logic            advance;
  logic [ROWS-1:0] pipe_col;
  logic [ROWS-1:0] new_col;
  logic            new_mark;
  logic [COLS-1:0] marker_nxt;
  logic [15:0]     lfsr_nxt;
  logic [6:0]      gap_calc;
  logic [ROWS-1:0] rd_sel;
  logic [ROWS-1:0] q_sel;
  logic            rd_bit;
  logic            hit_acc;

  assign advance   = step & run & ~clear;
  assign gen_state = state;

  // Solid everywhere except the GAP_H rows starting at gap_top.
  always_comb begin
    pipe_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      pipe_col[r] = !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP_H));
    end
  end

  assign new_col    = (state == PIPE) ? pipe_col : '0;
  assign new_mark   = (state == PIPE) && (pcnt == 16'd1);
  assign marker_nxt = {marker[COLS-2:0], new_mark};
  assign lfsr_nxt   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign gap_calc   = 7'(MARGIN + ((int'(lfsr[7:0]) * RANGE) >> 8));

  // Column selection for both ports; out-of-range columns select an empty column.
  always_comb begin
    rd_sel = '0;
    q_sel  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (rd_col == 6'(c)) rd_sel = field[c];
      if (q_col == 6'(c))  q_sel  = field[c];
    end
  end

  always_comb begin
    rd_bit  = 1'b0;
    hit_acc = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd_row == 6'(r)) rd_bit = rd_sel[r];
      if ((6'(r) >= q_lo) && (6'(r) <= q_hi)) hit_acc = hit_acc | q_sel[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) field[c] <= '0;
      marker <= '0;
    end else if (clear) begin
      for (int c = 0; c < COLS; c++) field[c] <= '0;
      marker <= '0;
    end else if (advance) begin
      field[0] <= new_col;
      for (int c = 1; c < COLS; c++) field[c] <= field[c-1];
      marker <= marker_nxt;
    end
  end

  // Generator: SPACE emits empty columns, PIPE emits PIPE_W columns sharing one gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SPACE;
      cnt     <= 16'(SPACING);
      pcnt    <= '0;
      lfsr    <= SEED;
      gap_top <= '0;
    end else if (clear) begin
      state <= SPACE;
      cnt   <= 16'(SPACING);
      pcnt  <= '0;
    end else if (advance) begin
      case (state)
        SPACE: begin
          if (cnt == 16'd1) begin
            state   <= PIPE;
            pcnt    <= 16'(PIPE_W);
            gap_top <= gap_calc;
            lfsr    <= lfsr_nxt;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        PIPE: begin
          if (pcnt == 16'd1) begin
            state <= SPACE;
            cnt   <= 16'(SPACING);
          end else begin
            pcnt <= pcnt - 16'd1;
          end
        end
        default: begin
          state <= SPACE;
          cnt   <= 16'(SPACING);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_pass <= 1'b0;
      score     <= '0;
    end else begin
      pipe_pass <= advance & marker_nxt[PASS_COL];
      if (clear) begin
        score <= '0;
      end else if (advance && marker_nxt[PASS_COL] && (score != {SCORE_W{1'b1}})) begin
        score <= score + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 1'b0;
      hit     <= 1'b0;
    end else begin
      rd_data <= rd_bit;
      hit     <= hit_acc;
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
module tb_obstacle_field;
  localparam int ROWS = 30, COLS = 40, PIPE_W = 2, SPACING = 8, GAP_H = 10, MARGIN = 2;
  localparam int PASS_COL = 35;
  localparam int PERIOD = PIPE_W + SPACING;
  localparam int RANGE = ROWS - 2*MARGIN - GAP_H + 1;

  logic       clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, clear = 1'b0;
  logic [5:0] rd_col = '0, rd_row = '0, q_col = '0, q_lo = '0, q_hi = '0;
  logic       rd_data, hit, pipe_pass;
  logic [7:0] score;
  logic [1:0] gen_state;
  logic       rd_data2, hit2, pipe_pass2;
  logic [1:0] score2;
  logic [1:0] gen_state2;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  obstacle_field dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .clear(clear),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data),
    .q_col(q_col), .q_lo(q_lo), .q_hi(q_hi), .hit(hit),
    .pipe_pass(pipe_pass), .score(score), .gen_state(gen_state)
  );

  obstacle_field #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .run(run), .step(step), .clear(clear),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data2),
    .q_col(q_col), .q_lo(q_lo), .q_hi(q_hi), .hit(hit2),
    .pipe_pass(pipe_pass2), .score(score2), .gen_state(gen_state2)
  );

  // Reference model: field as an array of columns, round position as an advance count.
  logic [63:0] mf [COLS];
  int          n;
  logic [15:0] mlfsr;
  int          mgap;
  int          passes;
  int          exp_rd, exp_hit, exp_pp;

  typedef struct {
    logic [5:0] rc, rr, qc, ql, qh;
    int         e_rd, e_hit;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t, n=%0d)", name, act, exp, $time, n);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [63:0] pipe_of(input int g);
    logic [63:0] v = '0;
    for (int r = 0; r < ROWS; r++) v[r] = (r < g) || (r >= g + GAP_H);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) mf[c] = '0;
    n = 0; mlfsr = 16'hACE1; mgap = 0; passes = 0; exp_pp = 0;
  endtask

  task automatic model_edge();
    int qc;
    exp_rd = 0;
    if (int'(rd_col) < COLS && int'(rd_row) < ROWS) exp_rd = int'(mf[int'(rd_col)][int'(rd_row)]);
    exp_hit = 0;
    qc = int'(q_col);
    if (qc < COLS)
      for (int r = int'(q_lo); r <= int'(q_hi); r++)
        if (r < ROWS && mf[qc][r]) exp_hit = 1;
    exp_pp = 0;
    if (clear) begin
      for (int c = 0; c < COLS; c++) mf[c] = '0;
      n = 0; passes = 0;
    end else if (run && step) begin
      n++;
      for (int c = COLS-1; c > 0; c--) mf[c] = mf[c-1];
      mf[0] = (((n-1) % PERIOD) >= SPACING) ? pipe_of(mgap) : '0;
      if (n % PERIOD == SPACING) begin
        mgap = MARGIN + ((int'(mlfsr[7:0]) * RANGE) >> 8);
        mlfsr = lfsr_step(mlfsr);
      end
      // The last pipe column leaves col0 on advance k*PERIOD and reaches PASS_COL PASS_COL advances later.
      if (n >= PASS_COL + PERIOD && (n - PASS_COL) % PERIOD == 0) begin
        exp_pp = 1; passes++;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("rd_data", int'(rd_data), exp_rd);
    chk("hit", int'(hit), exp_hit);
    chk("pipe_pass", int'(pipe_pass), exp_pp);
    chk("score", int'(score), passes > 255 ? 255 : passes);
    chk("gen_state", int'(gen_state), ((n % PERIOD) >= SPACING) ? 1 : 0);
    chk("score_sat2", int'(score2), passes > 3 ? 3 : passes);
    chk("rd_data2", int'(rd_data2), exp_rd);
    chk("hit2", int'(hit2), exp_hit);
    chk("pipe_pass2", int'(pipe_pass2), exp_pp);
    chk("gen_state2", int'(gen_state2), int'(gen_state));
  endtask

  task automatic steps(input int k);
    step = 1'b1;
    repeat (k) tick();
    step = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{rc: 6'd0,  rr: 6'd0,  qc: 6'd0,  ql: 6'd16, qh: 6'd25, e_rd: 1, e_hit: 0};
    vecs[1]  = '{rc: 6'd0,  rr: 6'd15, qc: 6'd0,  ql: 6'd14, qh: 6'd16, e_rd: 1, e_hit: 1};
    vecs[2]  = '{rc: 6'd0,  rr: 6'd16, qc: 6'd0,  ql: 6'd20, qh: 6'd10, e_rd: 0, e_hit: 0};
    vecs[3]  = '{rc: 6'd45, rr: 6'd0,  qc: 6'd45, ql: 6'd0,  qh: 6'd29, e_rd: 0, e_hit: 0};
    vecs[4]  = '{rc: 6'd0,  rr: 6'd25, qc: 6'd0,  ql: 6'd25, qh: 6'd26, e_rd: 0, e_hit: 1};
    vecs[5]  = '{rc: 6'd0,  rr: 6'd26, qc: 6'd0,  ql: 6'd29, qh: 6'd63, e_rd: 1, e_hit: 1};
    vecs[6]  = '{rc: 6'd0,  rr: 6'd40, qc: 6'd0,  ql: 6'd30, qh: 6'd63, e_rd: 0, e_hit: 0};
    vecs[7]  = '{rc: 6'd1,  rr: 6'd0,  qc: 6'd1,  ql: 6'd0,  qh: 6'd29, e_rd: 0, e_hit: 0};
    vecs[8]  = '{rc: 6'd0,  rr: 6'd29, qc: 6'd0,  ql: 6'd18, qh: 6'd18, e_rd: 1, e_hit: 0};
    vecs[9]  = '{rc: 6'd39, rr: 6'd0,  qc: 6'd39, ql: 6'd0,  qh: 6'd63, e_rd: 0, e_hit: 0};
    vecs[10] = '{rc: 6'd0,  rr: 6'd20, qc: 6'd0,  ql: 6'd0,  qh: 6'd0,  e_rd: 0, e_hit: 1};
    vecs[11] = '{rc: 6'd40, rr: 6'd5,  qc: 6'd0,  ql: 6'd15, qh: 6'd15, e_rd: 0, e_hit: 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_hit", int'(hit), 0);
    chk("reset_pipe_pass", int'(pipe_pass), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_gen_state", int'(gen_state), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;

    // Eight empty columns, then the first pipe with gap_top 16.
    steps(8);
    chk("space_gen_state", int'(gen_state), 1);
    steps(1);
    foreach (vecs[i]) begin
      rd_col = vecs[i].rc; rd_row = vecs[i].rr;
      q_col = vecs[i].qc; q_lo = vecs[i].ql; q_hi = vecs[i].qh;
      tick();
      chk($sformatf("vec%0d_rd", i), int'(rd_data), vecs[i].e_rd);
      chk($sformatf("vec%0d_hit", i), int'(hit), vecs[i].e_hit);
    end
    for (int r = 0; r < ROWS; r++) begin
      rd_col = 6'd0; rd_row = 6'(r);
      tick();
      chk($sformatf("col0_row%0d", r), int'(rd_data), (r < 16 || r >= 26) ? 1 : 0);
    end

    // Read col1 in the same cycle as step 10: the pre-shift (empty) column is returned.
    rd_col = 6'd1; rd_row = 6'd0;
    steps(1);
    chk("rd_pre_shift", int'(rd_data), 0);
    tick();
    chk("rd_post_shift", int'(rd_data), 1);

    // run=0 freezes everything.
    run = 1'b0;
    steps(20);
    chk("frozen_gen_state", int'(gen_state), 0);
    run = 1'b1;

    steps(34);
    chk("pre_pass", int'(pipe_pass), 0);
    steps(1);
    chk("first_pass", int'(pipe_pass), 1);
    chk("first_score", int'(score), 1);
    tick();
    chk("pass_one_cycle", int'(pipe_pass), 0);
    steps(40);
    chk("score_after5", int'(score), 5);
    chk("score2_saturated", int'(score2), 3);

    // Clear mid-PIPE together with step.
    steps(4);
    chk("mid_pipe", int'(gen_state), 1);
    clear = 1'b1; step = 1'b1;
    tick();
    clear = 1'b0; step = 1'b0;
    chk("clear_score", int'(score), 0);
    chk("clear_gen_state", int'(gen_state), 0);
    steps(9);
    for (int r = 0; r < ROWS; r++) begin
      rd_col = 6'd0; rd_row = 6'(r);
      tick();
    end

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom_range(0, 9) != 0);
      step   = ($urandom_range(0, 2) != 0);
      clear  = ($urandom_range(0, 199) == 0);
      rd_col = 6'($urandom_range(0, 45));
      rd_row = 6'($urandom_range(0, 35));
      q_col  = 6'($urandom_range(0, 45));
      q_lo   = 6'($urandom_range(0, 35));
      q_hi   = 6'($urandom_range(0, 35));
      tick();
    end
    clear = 1'b0;
    run = 1'b1;
    rd_col = 6'd0; rd_row = 6'd0; q_col = 6'd0; q_lo = 6'd0; q_hi = 6'd29;
    steps(60);

    // Asynchronous reset mid-run: outputs drop without a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_hit", int'(hit), 0);
    chk("arst_pipe_pass", int'(pipe_pass), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_gen_state", int'(gen_state), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    steps(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_field.md
Name: obstacle_field

Overview:
Parametrised scrolling obstacle store and generator for the flappy game. It holds a ROWS x COLS bitmap of pipe cells and scrolls it one column per `step` pulse. It generates pipe columns internally, with LFSR-randomised gap positions and configurable pipe width and spacing. It serves a 1-cycle-latency pixel read port for the VGA draw FSM, a registered collision query for the bird logic, and a saturating pass counter for score.

Parameters:
ROWS, 30, field height in cells (max 64)
COLS, 40, field width in columns (max 64)
PIPE_W, 2, consecutive solid columns per pipe (>=1)
SPACING, 8, empty columns between pipes, and before the first pipe (>=1)
GAP_H, 10, gap height in rows
MARGIN, 2, minimum solid rows above and below the gap
SEED, 16'hACE1, LFSR reset value (nonzero)
PASS_COL, 35, column at which a pipe counts as passed (<COLS)
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
run  in  1  1 = step pulses honoured; 0 = field frozen
step  in  1  one-cycle scroll enable (frame tick)
clear  in  1  synchronous clear of field, generator, marker and score; LFSR kept
rd_col  in  6  read column index
rd_row  in  6  read row index
rd_data  out  1  cell value, registered
q_col  in  6  collision query column
q_lo  in  6  query top row, inclusive
q_hi  in  6  query bottom row, inclusive
hit  out  1  registered OR of cells q_lo..q_hi in column q_col
pipe_pass  out  1  one-cycle pulse when a pipe's last column reaches PASS_COL
score  out  SCORE_W  saturating pass count
gen_state  out  2  generator state (debug)

Behaviour:
- Reset (async, active-high):
  - field, marker, rd_data, hit, pipe_pass and score are 0.
  - LFSR = SEED.
  - Generator in SPACE with cnt = SPACING.
- Advance = step & run & ~clear. Clear has priority over step. A clear during reset is irrelevant.
- On advance:
  - col[i] <= col[i-1] for i = 1..COLS-1.
  - col[0] <= new column.
  - col[COLS-1] is discarded.
  - The updated field is visible from the next cycle.
- Generator FSM, states SPACE=0, PIPE=1:
  - SPACE: new column is all 0. cnt decrements on each advance. When the advance that emits with cnt==1 completes, go to PIPE with pcnt = PIPE_W.
  - Gap latch on the SPACE->PIPE transition:
    - RANGE = ROWS - 2*MARGIN - GAP_H + 1.
    - gap_top = MARGIN + ((lfsr[7:0] * RANGE) >> 8).
    - The LFSR then advances once: 16-bit Galois, taps mask 16'hB400, shift right.
  - PIPE: new column row r = 1 unless gap_top <= r < gap_top + GAP_H. Same gap_top for all PIPE_W columns. pcnt decrements per advance.
  - The last pipe column (pcnt==1) writes 1 into marker[0]; all other columns write 0. marker shifts alongside the field.
  - After the last pipe column, go to SPACE with cnt = SPACING.
  - Period is PIPE_W + SPACING advances.
- Score:
  - On the advance that moves a 1 into marker[PASS_COL], pipe_pass = 1 for exactly the next cycle.
  - score increments and saturates at 2^SCORE_W-1 (no wrap).
- Read port:
  - rd_data(t+1) = field[rd_col][rd_row] as held in cycle t.
  - If step coincides with the read, the pre-shift value is returned.
  - An out-of-range index returns 0.
- Collision:
  - hit(t+1) = OR over r in [q_lo, q_hi] ∩ [0, ROWS-1] of field[q_col][r] at cycle t.
  - q_lo > q_hi or q_col >= COLS gives 0.
- clear:
  - Next cycle the field, marker and score are 0, and the generator is in SPACE with cnt = SPACING.
  - LFSR is unchanged, so successive rounds differ.
  - rd_data and hit read the cleared field from the following cycle.
- run=0: step is ignored entirely; no counter or LFSR change.

Test Plan:
1. Reset, defaults, run=1, 8 steps -> every cell 0; 9th step -> col0 rows 0-15 and 26-29 = 1, rows 16-25 = 0 (SEED gives lfsr[7:0]=0xE1, gap_top=16).
2. Continue to step 10 -> col0 and col1 identical pipe columns; step 11 -> col0 all 0; step 19 -> new pipe column whose gap comes from the advanced LFSR; gap_top always within 2..18.
3. Step 45 -> pipe_pass high for exactly 1 cycle, score=1; with SCORE_W=2, five passes -> score holds at 3.
4. After the first pipe, q_col=0, q_lo=16, q_hi=25 -> hit=0; q_lo=14, q_hi=16 -> hit=1; q_lo=20, q_hi=10 -> hit=0; rd_col=45 -> rd_data=0.
5. step and rd same cycle on col1 -> rd_data returns the pre-shift col1; run=0 with 20 steps -> field unchanged, gen_state unchanged.
6. clear asserted mid-PIPE together with step -> field all 0, score 0, next pipe after 8 steps with gap from the current LFSR (not SEED); async reset mid-run -> all outputs 0 immediately.
